ram_burst: RTL and testbench

RAM_BURST -- requirements
Module: ram_burst

---
 rtl/ram_burst.sv | 129 ++++++++++++
 tb/tb_ram_burst.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst.sv
// Single-port burst RAM: wrapping read/write bursts plus a whole-array zero-fill sweep.
// Read words appear on data_io one cycle after their access edge; ena=0 stalls bursts, never the sweep.
module ram_burst #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              start,
  input  logic              wena,
  input  logic              clr,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  inout  wire  [DATA_W-1:0] data_io,
  output logic              busy,
  output logic              valid,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W+1)'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdat;
  logic              step;

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    count_d    = count_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;
    mem_wdat   = '0;
    step       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d    = ST_CLEAR;
          cur_addr_d = '0;
          count_d    = DEPTH_CNT;
        end else if (start) begin
          // A zero-length burst completes immediately without leaving IDLE.
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = wena ? ST_WRITE : ST_READ;
            cur_addr_d = base;
            count_d    = (len > DEPTH_CNT) ? DEPTH_CNT : len;
          end
        end
      end
      ST_WRITE: begin
        if (ena) begin
          mem_we   = 1'b1;
          mem_wdat = data_io;
          step     = 1'b1;
        end
      end
      ST_READ: begin
        if (ena) begin
          rdata_d = mem[cur_addr_q];
          valid_d = 1'b1;
          step    = 1'b1;
        end
      end
      ST_CLEAR: begin
        mem_we = 1'b1;
        step   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (step) begin
      cur_addr_d = cur_addr_q + 1'b1;
      count_d    = count_q - ONE_CNT;
      if (count_q == ONE_CNT) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  // Array and read register sit outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cur_addr_q] <= mem_wdat;
    rdata_q <= rdata_d;
  end

  assign data_io  = valid_q ? rdata_q : {DATA_W{1'bz}};
  assign busy     = (state_q != ST_IDLE);
  assign valid    = valid_q;
  assign done     = done_q;
  assign cur_addr = cur_addr_q;

endmodule

// File: tb/tb_ram_burst.sv
// Randomized bench for ram_burst: a flat array model predicts every read word and burst timing.
module tb_ram_burst;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 32;

  logic          clk = 1'b0;
  logic          rst, ena, start, wena, clr;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic          busy, valid, done;
  logic [AW-1:0] cur_addr;
  logic          tb_oe;
  logic [DW-1:0] tb_dat;
  wire  [DW-1:0] data_io;

  assign data_io = tb_oe ? tb_dat : {DW{1'bz}};

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [D];
  logic [DW-1:0] wbuf [64];

  ram_burst #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .wena(wena), .clr(clr),
    .base(base), .len(len), .data_io(data_io), .busy(busy), .valid(valid),
    .done(done), .cur_addr(cur_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One read or write burst; spurious start/clr pulses are thrown in while busy.
  task automatic burst(input bit is_wr, input int b, input int l, input bit stall);
    int n;
    int issued;
    int cyc;
    bit prev;
    bit fin;
    n = (l > D) ? D : l;
    issued = 0; cyc = 0; prev = 0; fin = 0;
    @(negedge clk);
    start = 1'b1; clr = 1'b0; wena = is_wr; base = b[AW-1:0]; len = l[AW:0];
    ena = 1'($urandom); tb_oe = is_wr;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 400) begin
      check("busy", busy, (issued < n));
      check("cur_addr", cur_addr, (b + issued) % D);
      check("valid", valid, (!is_wr && prev));
      check("done", done, (prev && issued == n));
      if (prev && !is_wr) check("rdata", data_io, model[(b + issued - 1) % D]);
      if (prev && issued == n) begin
        fin = 1;
      end else begin
        ena   = stall ? ($urandom_range(3) != 0) : 1'b1;
        start = ($urandom_range(4) == 0);
        clr   = ($urandom_range(6) == 0);
        wena  = 1'($urandom);
        base  = AW'($urandom);
        len   = (AW+1)'($urandom);
        if (is_wr) tb_dat = wbuf[issued];
        prev = ena;
        if (ena) begin
          if (is_wr) model[(b + issued) % D] = wbuf[issued];
          issued++;
        end
      end
      cyc++;
      if (!fin) @(negedge clk);
    end
    if (!fin) check("timeout", 0, 1);
    start = 1'b0; clr = 1'b0; ena = 1'b0; tb_oe = 1'b0;
    @(negedge clk);
    check("post_busy", busy, 0);
    check("post_valid", valid, 0);
    check("post_done", done, 0);
  endtask

  task automatic clear_sweep();
    @(negedge clk);
    clr = 1'b1; start = 1'b1; wena = 1'($urandom); base = AW'($urandom); len = 6'd5;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    for (int i = 0; i < D; i++) begin
      check("clr_busy", busy, 1);
      check("clr_addr", cur_addr, i);
      check("clr_done", done, 0);
      check("clr_valid", valid, 0);
      ena   = 1'($urandom);
      start = ($urandom_range(3) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < D; i++) model[i] = '0;
    check("clr_end_busy", busy, 0);
    check("clr_end_done", done, 1);
    @(negedge clk);
    check("clr_end_done2", done, 0);
  endtask

  task automatic zero_len();
    @(negedge clk);
    start = 1'b1; wena = 1'($urandom); base = AW'($urandom); len = '0; ena = 1'b1;
    @(negedge clk);
    start = 1'b0; ena = 1'b0;
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    check("len0_valid", valid, 0);
    @(negedge clk);
    check("len0_done2", done, 0);
  endtask

  task automatic reset_mid_write(input int b);
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    @(negedge clk);
    start = 1'b1; wena = 1'b1; base = b[AW-1:0]; len = 6'd4; tb_oe = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ena = 1'b1; tb_dat = wbuf[k]; model[(b + k) % D] = wbuf[k];
      @(negedge clk);
    end
    check("rw_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check("rw_busy", busy, 0);
    check("rw_valid", valid, 0);
    check("rw_done", done, 0);
    check("rw_addr", cur_addr, 0);
    @(negedge clk);
    rst = 1'b0; ena = 1'b0; tb_oe = 1'b0;
  endtask

  task automatic reset_mid_read(input int b);
    @(negedge clk);
    start = 1'b1; wena = 1'b0; base = b[AW-1:0]; len = 6'd4;
    @(negedge clk);
    start = 1'b0; ena = 1'b1;
    @(negedge clk);
    check("rr_valid_pre", valid, 1);
    check("rr_data_pre", data_io, model[b % D]);
    rst = 1'b1;
    #1;
    check("rr_valid", valid, 0);
    check("rr_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0; ena = 1'b0;
  endtask

  initial begin
    int b;
    int l;
    rst = 1'b1; ena = 1'b0; start = 1'b0; wena = 1'b0; clr = 1'b0;
    base = '0; len = '0; tb_oe = 1'b0; tb_dat = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_done", done, 0);
    check("rst_addr", cur_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    clear_sweep();
    burst(0, 0, 32, 0);

    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3;
    burst(1, 1, 3, 0);
    burst(0, 1, 3, 0);

    wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; wbuf[2] = 32'hA2; wbuf[3] = 32'hA3;
    burst(1, 30, 4, 0);
    burst(0, 0, 2, 0);
    burst(0, 30, 2, 0);
    burst(0, 30, 4, 1);

    for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
    burst(1, 7, 40, 1);
    burst(0, 19, 33, 1);

    zero_len();
    reset_mid_write(2);
    burst(0, 0, 8, 0);
    reset_mid_read(5);
    burst(0, 28, 10, 1);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
      b = $urandom_range(D - 1);
      l = $urandom_range(33, 1);
      burst(1'($urandom), b, l, 1);
    end
    zero_len();
    clear_sweep();
    wbuf[0] = 32'hDEAD_BEEF;
    burst(1, 31, 1, 1);
    burst(0, 0, 32, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
